// File: rtl/fwd_select_tracker.sv
// Dual-issue operand-forwarding controller.
// Tracks destination tags of the EX and MEM bundles and registers the EX-stage
// operand mux selects one cycle after ID; also raises the load-use stall and
// the intra-bundle dependency flag for the issue logic.
module fwd_select_tracker #(
    parameter int REG_BITS = 5,
    parameter int SEL_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                flush,
    input  logic                id_valid_a,
    input  logic                id_valid_b,
    input  logic [REG_BITS-1:0] id_rs_a,
    input  logic [REG_BITS-1:0] id_rt_a,
    input  logic [REG_BITS-1:0] id_rs_b,
    input  logic [REG_BITS-1:0] id_rt_b,
    input  logic [REG_BITS-1:0] id_rd_a,
    input  logic [REG_BITS-1:0] id_rd_b,
    input  logic                id_regwrite_a,
    input  logic                id_regwrite_b,
    input  logic                id_memread_a,
    input  logic                id_memread_b,
    output logic [SEL_BITS-1:0] sel_rs_a,
    output logic [SEL_BITS-1:0] sel_rt_a,
    output logic [SEL_BITS-1:0] sel_rs_b,
    output logic [SEL_BITS-1:0] sel_rt_b,
    output logic                load_use_stall,
    output logic                pair_dep
);

    typedef enum logic [SEL_BITS-1:0] {
        SEL_RF   = 'd0,
        SEL_EXA  = 'd1,
        SEL_EXB  = 'd2,
        SEL_MEMA = 'd3,
        SEL_MEMB = 'd4
    } sel_t;

    // Index 0 = slot A (older), index 1 = slot B (younger).
    logic [1:0]               ex_valid, ex_regwrite, ex_memread;
    logic [1:0][REG_BITS-1:0] ex_rd;
    logic [1:0]               mem_valid, mem_regwrite;
    logic [1:0][REG_BITS-1:0] mem_rd;
    // The WB record is never a forward source and carries nothing observable,
    // so entries simply age out of MEM without a third stage of storage.

    logic [1:0]    ex_live, mem_live;
    logic [1:0]    ex_load_hit;
    sel_t          nxt_rs_a, nxt_rt_a, nxt_rs_b, nxt_rt_b;

    // Highest-priority producer of a source tag: youngest EX first, then MEM.
    function automatic sel_t pick(input logic [REG_BITS-1:0] tag);
        if (ex_live[1] && ex_rd[1] == tag)        return SEL_EXB;
        else if (ex_live[0] && ex_rd[0] == tag)   return SEL_EXA;
        else if (mem_live[1] && mem_rd[1] == tag) return SEL_MEMB;
        else if (mem_live[0] && mem_rd[0] == tag) return SEL_MEMA;
        else                                      return SEL_RF;
    endfunction

    // Does a tag match any source of a valid ID slot?
    function automatic logic id_src_hit(input logic [REG_BITS-1:0] tag);
        return (id_valid_a && (tag == id_rs_a || tag == id_rt_a)) ||
               (id_valid_b && (tag == id_rs_b || tag == id_rt_b));
    endfunction

    // Liveness, hazard detection and next select codes.
    always_comb begin
        ex_live     = '0;
        mem_live    = '0;
        ex_load_hit = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            ex_live[i]     = ex_valid[i] & ex_regwrite[i] & (ex_rd[i] != '0);
            mem_live[i]    = mem_valid[i] & mem_regwrite[i] & (mem_rd[i] != '0);
            ex_load_hit[i] = ex_live[i] & ex_memread[i] & id_src_hit(ex_rd[i]);
        end
        load_use_stall = !rst && !flush && (|ex_load_hit);
        pair_dep = !rst && id_valid_a && id_valid_b && id_regwrite_a &&
                   (id_rd_a != '0) && (id_rd_a == id_rs_b || id_rd_a == id_rt_b);
        nxt_rs_a = id_valid_a ? pick(id_rs_a) : SEL_RF;
        nxt_rt_a = id_valid_a ? pick(id_rt_a) : SEL_RF;
        nxt_rs_b = id_valid_b ? pick(id_rs_b) : SEL_RF;
        nxt_rt_b = id_valid_b ? pick(id_rt_b) : SEL_RF;
    end

    // Pipeline advance: reset > hold > flush/stall bubble > normal issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= '0;
            ex_regwrite  <= '0;
            ex_memread   <= '0;
            ex_rd        <= '0;
            mem_valid    <= '0;
            mem_regwrite <= '0;
            mem_rd       <= '0;
            sel_rs_a     <= SEL_RF;
            sel_rt_a     <= SEL_RF;
            sel_rs_b     <= SEL_RF;
            sel_rt_b     <= SEL_RF;
        end else if (!hold) begin
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            if (flush || load_use_stall) begin
                ex_valid    <= '0;
                ex_regwrite <= '0;
                ex_memread  <= '0;
                ex_rd       <= '0;
                sel_rs_a    <= SEL_RF;
                sel_rt_a    <= SEL_RF;
                sel_rs_b    <= SEL_RF;
                sel_rt_b    <= SEL_RF;
            end else begin
                ex_valid    <= {id_valid_b, id_valid_a};
                ex_regwrite <= {id_regwrite_b, id_regwrite_a};
                ex_memread  <= {id_memread_b, id_memread_a};
                ex_rd       <= {id_rd_b, id_rd_a};
                sel_rs_a    <= nxt_rs_a;
                sel_rt_a    <= nxt_rt_a;
                sel_rs_b    <= nxt_rs_b;
                sel_rt_b    <= nxt_rt_b;
            end
        end
    end

endmodule

// File: tb/tb_fwd_select_tracker.sv
// Self-checking bench for fwd_select_tracker: expected select vectors are
// queued as each ID bundle is driven and compared one edge later.
module tb_fwd_select_tracker;

    logic       clk = 1'b0;
    logic       rst, hold, flush;
    logic       id_valid_a, id_valid_b;
    logic [4:0] id_rs_a, id_rt_a, id_rs_b, id_rt_b, id_rd_a, id_rd_b;
    logic       id_regwrite_a, id_regwrite_b, id_memread_a, id_memread_b;
    logic [2:0] sel_rs_a, sel_rt_a, sel_rs_b, sel_rt_b;
    logic       load_use_stall, pair_dep;

    typedef struct {
        string      tag;
        logic [11:0] sel;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fwd_select_tracker #(.REG_BITS(5), .SEL_BITS(3)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid_a(id_valid_a), .id_valid_b(id_valid_b),
        .id_rs_a(id_rs_a), .id_rt_a(id_rt_a), .id_rs_b(id_rs_b), .id_rt_b(id_rt_b),
        .id_rd_a(id_rd_a), .id_rd_b(id_rd_b),
        .id_regwrite_a(id_regwrite_a), .id_regwrite_b(id_regwrite_b),
        .id_memread_a(id_memread_a), .id_memread_b(id_memread_b),
        .sel_rs_a(sel_rs_a), .sel_rt_a(sel_rt_a), .sel_rs_b(sel_rs_b), .sel_rt_b(sel_rt_b),
        .load_use_stall(load_use_stall), .pair_dep(pair_dep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packs {sel_rs_a, sel_rt_a, sel_rs_b, sel_rt_b}.
    function automatic logic [11:0] S(input int a, input int b, input int c, input int d);
        return {3'(a), 3'(b), 3'(c), 3'(d)};
    endfunction

    task automatic idle();
        id_valid_a = 0; id_valid_b = 0;
        id_rs_a = 0; id_rt_a = 0; id_rs_b = 0; id_rt_b = 0;
        id_rd_a = 0; id_rd_b = 0;
        id_regwrite_a = 0; id_regwrite_b = 0;
        id_memread_a = 0; id_memread_b = 0;
    endtask

    task automatic rand_id();
        id_valid_a = 1'($urandom); id_valid_b = 1'($urandom);
        id_rs_a = 5'($urandom); id_rt_a = 5'($urandom);
        id_rs_b = 5'($urandom); id_rt_b = 5'($urandom);
        id_rd_a = 5'($urandom); id_rd_b = 5'($urandom);
        id_regwrite_a = 1'($urandom); id_regwrite_b = 1'($urandom);
        id_memread_a = 1'($urandom); id_memread_b = 1'($urandom);
    endtask

    // Queue the expected selects for the bundle now in ID, clock it, compare.
    task automatic cyc(input string tag, input logic [11:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk(x.tag, 32'({sel_rs_a, sel_rt_a, sel_rs_b, sel_rt_b}), 32'(x.sel));
    endtask

    task automatic drain();
        idle();
        repeat (3) cyc("drain", 12'd0);
    endtask

    initial begin
        rst = 1; hold = 0; flush = 0;
        idle();

        // Reset with random ID traffic
        for (int i = 0; i < 2; i++) begin
            rand_id();
            #1;
            chk("rst_stall", 32'(load_use_stall), 32'd0);
            chk("rst_pair", 32'(pair_dep), 32'd0);
            cyc("rst_sel", 12'd0);
        end
        rst = 0;
        idle();
        cyc("post_rst", 12'd0);

        // Back-to-back ALU forwarding, EX then MEM, WB never a source
        idle(); id_valid_a = 1; id_rd_a = 5; id_regwrite_a = 1;
        cyc("b2b_prod", 12'd0);
        idle(); id_valid_a = 1; id_rs_a = 5;
        cyc("b2b_exa", S(1, 0, 0, 0));
        idle(); id_valid_b = 1; id_rt_b = 5;
        cyc("b2b_mema", S(0, 0, 0, 3));
        idle(); id_valid_a = 1; id_rs_a = 5;
        cyc("b2b_wb_none", 12'd0);
        drain();

        // Priority: slot B beats slot A, EX beats MEM
        idle(); id_valid_a = 1; id_rd_a = 7; id_regwrite_a = 1;
        id_valid_b = 1; id_rd_b = 7; id_regwrite_b = 1;
        cyc("pri_prod", 12'd0);
        idle(); id_valid_a = 1; id_rs_a = 7;
        cyc("pri_exb", S(2, 0, 0, 0));
        idle(); id_valid_a = 1; id_rt_a = 7;
        cyc("pri_memb", S(0, 4, 0, 0));
        drain();
        idle(); id_valid_b = 1; id_rd_b = 6; id_regwrite_b = 1;
        cyc("pri2_prodb", 12'd0);
        idle(); id_valid_a = 1; id_rd_a = 6; id_regwrite_a = 1;
        cyc("pri2_proda", 12'd0);
        idle(); id_valid_b = 1; id_rs_b = 6;
        cyc("pri_exa_over_memb", S(0, 0, 1, 0));
        drain();

        // Register 0 is never forwarded
        idle(); id_valid_a = 1; id_regwrite_a = 1; id_valid_b = 1; id_regwrite_b = 1;
        cyc("r0_prod", 12'd0);
        idle(); id_valid_a = 1; id_valid_b = 1;
        cyc("r0_none", 12'd0);
        drain();

        // Invalid ID slot drives 000 even on a tag match
        idle(); id_valid_a = 1; id_rd_a = 8; id_regwrite_a = 1;
        cyc("inv_prod", 12'd0);
        idle(); id_rs_a = 8; id_valid_b = 1; id_rt_b = 8;
        cyc("inv_slot", S(0, 0, 0, 1));
        drain();

        // Load-use: bubble, then forward from MEM
        idle(); id_valid_a = 1; id_rd_a = 9; id_regwrite_a = 1; id_memread_a = 1;
        cyc("lu_prod", 12'd0);
        idle(); id_valid_b = 1; id_rs_b = 9;
        #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
        cyc("lu_bubble", 12'd0);
        #1 chk("lu_stall_clear", 32'(load_use_stall), 32'd0);
        cyc("lu_fwd", S(0, 0, 3, 0));
        drain();

        // Hold during a load-use stall, then flush
        idle(); id_valid_a = 1; id_rd_a = 4; id_regwrite_a = 1;
        cyc("hf_prod", 12'd0);
        idle(); id_valid_a = 1; id_rs_a = 4; id_rd_a = 9; id_regwrite_a = 1; id_memread_a = 1;
        cyc("hf_load", S(1, 0, 0, 0));
        idle(); id_valid_b = 1; id_rs_b = 9; hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hf_hold_stall", 32'(load_use_stall), 32'd1);
            cyc("hf_hold_sel", S(1, 0, 0, 0));
        end
        hold = 0; flush = 1;
        #1 chk("hf_flush_stall", 32'(load_use_stall), 32'd0);
        cyc("hf_flush", 12'd0);
        flush = 0;
        #1 chk("hf_after_stall", 32'(load_use_stall), 32'd0);
        cyc("hf_after", S(0, 0, 3, 0));
        drain();

        // Intra-bundle dependency flag
        idle(); id_valid_a = 1; id_rd_a = 3; id_regwrite_a = 1; id_valid_b = 1; id_rt_b = 3;
        #1 chk("pair_set", 32'(pair_dep), 32'd1);
        cyc("pair_sel", 12'd0);
        idle(); id_valid_a = 1; id_rd_a = 3; id_valid_b = 1; id_rs_b = 3;
        #1 chk("pair_norw", 32'(pair_dep), 32'd0);
        id_regwrite_a = 1; id_valid_b = 0;
        #1 chk("pair_binv", 32'(pair_dep), 32'd0);
        id_valid_b = 1;
        #1 chk("pair_rs", 32'(pair_dep), 32'd1);
        id_rd_a = 0; id_rs_b = 0;
        #1 chk("pair_r0", 32'(pair_dep), 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
